data_mem_responder: RTL

//  Responder side of the cpu_core data-memory port (mem_addr/mem_wdata/mem_ctrl_signal -> mem_rdata/mem_stall).

---
 rtl/mem_defs_pkg.sv | 48 ++++
 rtl/mem_lane_align.sv | 59 +++++
 rtl/data_mem_responder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mem_defs_pkg.sv
// Shared definitions for the cpu_core data-memory responder: request field
// positions, access-size codes, responder FSM states and request decode helpers.
package mem_defs_pkg;

    localparam int MEM_EN = 4;
    localparam int MEM_WR = 3;

    typedef enum logic [2:0] {
        SIZE_WORD   = 3'b000,
        SIZE_HALF_U = 3'b001,
        SIZE_HALF_S = 3'b010,
        SIZE_BYTE_U = 3'b011,
        SIZE_BYTE_S = 3'b100
    } mem_size_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_DONE
    } resp_state_t;

    // Map the raw size field onto a known size; unused codes behave as a word access.
    function automatic mem_size_t decode_size(input logic [2:0] code);
        mem_size_t size;
        case (code)
            3'b001:  size = SIZE_HALF_U;
            3'b010:  size = SIZE_HALF_S;
            3'b011:  size = SIZE_BYTE_U;
            3'b100:  size = SIZE_BYTE_S;
            default: size = SIZE_WORD;
        endcase
        return size;
    endfunction

    // Words must sit on a 4-byte boundary, halves on a 2-byte boundary, bytes anywhere.
    function automatic logic is_aligned(input mem_size_t size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            SIZE_WORD:                ok = (addr_lo == 2'b00);
            SIZE_HALF_U, SIZE_HALF_S: ok = (addr_lo[0] == 1'b0);
            default:                  ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the 32-bit SRAM bus and the CPU: byte enables,
// store-data replication and load-data lane extraction with sign/zero extension.
module mem_lane_align
    import mem_defs_pkg::*;
(
    input  mem_size_t   size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_raw,
    output logic [3:0]  be_n,
    output logic [31:0] store_repl,
    output logic [31:0] load_ext
);

    logic [3:0]  lane_mask;
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    // Choose the active lanes and copy the low-order store data onto every lane
    // of that width, so whichever lanes are enabled carry the right bytes.
    always_comb begin
        lane_mask  = 4'b1111;
        store_repl = store_data;
        case (size)
            SIZE_HALF_U, SIZE_HALF_S: begin
                lane_mask  = addr_lo[1] ? 4'b1100 : 4'b0011;
                store_repl = {2{store_data[15:0]}};
            end
            SIZE_BYTE_U, SIZE_BYTE_S: begin
                lane_mask  = 4'b0001 << addr_lo;
                store_repl = {4{store_data[7:0]}};
            end
            default: begin
                lane_mask  = 4'b1111;
                store_repl = store_data;
            end
        endcase
        be_n = ~lane_mask;
    end

    // Pull the addressed half/byte out of the full SRAM word and extend it to 32 bits.
    always_comb begin
        half_sel = addr_lo[1] ? load_raw[31:16] : load_raw[15:0];
        case (addr_lo)
            2'd0:    byte_sel = load_raw[7:0];
            2'd1:    byte_sel = load_raw[15:8];
            2'd2:    byte_sel = load_raw[23:16];
            default: byte_sel = load_raw[31:24];
        endcase
        case (size)
            SIZE_HALF_U: load_ext = {16'h0000, half_sel};
            SIZE_HALF_S: load_ext = {{16{half_sel[15]}}, half_sel};
            SIZE_BYTE_U: load_ext = {24'h000000, byte_sel};
            SIZE_BYTE_S: load_ext = {{24{byte_sel[7]}}, byte_sel};
            default:     load_ext = load_raw;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the cpu_core data-memory port. Accepts one load/store at a time,
// stalls the CPU while it runs a multi-cycle access on an asynchronous SRAM,
// and returns extended load data in the DONE cycle.
module data_mem_responder
    import mem_defs_pkg::*;
#(
    parameter int RD_WAIT  = 2,
    parameter int WE_PULSE = 2,
    parameter int RAM_AW   = 20
) (
    input  logic              clk_50M,
    input  logic              rst_n,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [4:0]        mem_ctrl_signal,
    output logic [31:0]       mem_rdata,
    output logic              mem_stall,
    output logic              addr_err,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [3:0]        ram_be_n,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic [31:0]       ram_data_o,
    output logic              ram_data_oe,
    input  logic [31:0]       ram_data_i
);

    localparam int CNT_MAX = (RD_WAIT > WE_PULSE) ? RD_WAIT : WE_PULSE;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] WE_LAST = CNT_W'(WE_PULSE - 1);

    resp_state_t        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RAM_AW+1:0]  addr_q, addr_d;
    mem_size_t          size_q, size_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;

    logic               req_en;
    logic               req_wr;
    mem_size_t          req_size;
    logic               req_aligned;
    logic               unused_addr_hi;

    logic [3:0]         lane_be_n;
    logic [31:0]        lane_store;
    logic [31:0]        lane_load;

    assign req_en         = mem_ctrl_signal[MEM_EN];
    assign req_wr         = mem_ctrl_signal[MEM_WR];
    assign req_size       = decode_size(mem_ctrl_signal[2:0]);
    assign req_aligned    = is_aligned(req_size, mem_addr[1:0]);
    assign unused_addr_hi = ^mem_addr[31:RAM_AW+2];

    // Lane steering always works from the latched request so the SRAM sees
    // stable enables and data for the whole access.
    mem_lane_align u_lane_align (
        .size       (size_q),
        .addr_lo    (addr_q[1:0]),
        .store_data (wdata_q),
        .load_raw   (ram_data_i),
        .be_n       (lane_be_n),
        .store_repl (lane_store),
        .load_ext   (lane_load)
    );

    assign ram_addr   = addr_q[RAM_AW+1:2];
    assign ram_data_o = lane_store;
    assign mem_rdata  = rdata_q;

    // Next-state and strobe decode. Strobes come straight from the state so an
    // asynchronous reset drops them the moment the state register clears. At the
    // end of a write we_n and data_oe return together on the DONE edge; the pad
    // data value itself stays held from the latched store data.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        size_d      = size_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        mem_stall   = 1'b0;
        addr_err    = 1'b0;
        ram_ce_n    = 1'b1;
        ram_oe_n    = 1'b1;
        ram_we_n    = 1'b1;
        ram_be_n    = 4'hF;
        ram_data_oe = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_en) begin
                    if (req_aligned) begin
                        mem_stall = 1'b1;
                        addr_d    = mem_addr[RAM_AW+1:0];
                        size_d    = req_size;
                        wdata_d   = mem_wdata;
                        cnt_d     = '0;
                        state_d   = req_wr ? ST_WR_SETUP : ST_RD;
                    end else begin
                        addr_err  = 1'b1;
                    end
                end
            end

            ST_RD: begin
                mem_stall = 1'b1;
                ram_ce_n  = 1'b0;
                ram_oe_n  = 1'b0;
                ram_be_n  = 4'b0000;
                if (cnt_q == RD_LAST) begin
                    rdata_d = lane_load;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end

            ST_WR_SETUP: begin
                mem_stall   = 1'b1;
                ram_ce_n    = 1'b0;
                ram_be_n    = lane_be_n;
                ram_data_oe = 1'b1;
                cnt_d       = '0;
                state_d     = ST_WR_PULSE;
            end

            ST_WR_PULSE: begin
                mem_stall   = 1'b1;
                ram_ce_n    = 1'b0;
                ram_we_n    = 1'b0;
                ram_be_n    = lane_be_n;
                ram_data_oe = 1'b1;
                if (cnt_q == WE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!rst_n) begin
            mem_stall = 1'b0;
            addr_err  = 1'b0;
        end
    end

    // State, wait counter, request latches and load result register.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            size_q  <= SIZE_WORD;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule
